// File: rtl/seq_tail_light_ctrl_pkg.sv
// Shared types and helpers for the sequential tail-light controller.
// Build option: SEQ_TAIL_BRAKE_EN adds a brake request that lights idle sides.
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  localparam int unsigned MAX_LAMPS = 8;

  // Thermometer mask: the lowest 'step' lamps lit, counted from the inner lamp.
  function automatic logic [MAX_LAMPS-1:0] thermo(input logic [3:0] step);
    logic [MAX_LAMPS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      mask[i] = (4'(i) < step);
    end
    return mask;
  endfunction

  // Request decode: hazard wins, and both turn requests together also mean hazard.
  function automatic mode_t decode_mode(input logic left, input logic right, input logic hazard);
    if (hazard || (left && right)) return MODE_HAZARD;
    else if (left)                 return MODE_LEFT;
    else if (right)                return MODE_RIGHT;
    else                           return MODE_IDLE;
  endfunction

endpackage

// File: rtl/seq_tail_light_ctrl_if.sv
// Request/lamp bundle between the switch debouncers, the controller and the lamp drivers.
// Build option: SEQ_TAIL_BRAKE_EN adds the brake request signal.
interface seq_tail_light_ctrl_if #(
  parameter int unsigned LAMPS = 3
);
  import tail_light_pkg::*;

  logic             left;
  logic             right;
  logic             hazard;
`ifdef SEQ_TAIL_BRAKE_EN
  logic             brake;
`endif
  logic [LAMPS-1:0] lamps_l;
  logic [LAMPS-1:0] lamps_r;
  mode_t            mode;
  logic             step_tick;

`ifdef SEQ_TAIL_BRAKE_EN
  modport master (output left, right, hazard, brake,
                  input  lamps_l, lamps_r, mode, step_tick);
  modport slave  (input  left, right, hazard, brake,
                  output lamps_l, lamps_r, mode, step_tick);
`else
  modport master (output left, right, hazard,
                  input  lamps_l, lamps_r, mode, step_tick);
  modport slave  (input  left, right, hazard,
                  output lamps_l, lamps_r, mode, step_tick);
`endif

endinterface

// File: rtl/seq_tail_light_ctrl_tick_prescaler.sv
// Animation-step prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
// A clear restarts the count so a new mode always gets a full first step.
module tail_tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/seq_tail_light_ctrl.sv
// Sequential tail-light controller: decodes turn/hazard requests and animates per-side lamps.
// Build option: SEQ_TAIL_BRAKE_EN adds brake lighting on non-animated sides.
module seq_tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seq_tail_light_ctrl_if.slave  bus
);

  localparam int unsigned SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  mode_t            mode_q, mode_d, decoded;
  logic [SW-1:0]    step_q, step_d;
  logic             mode_change;
  logic             tick;
  logic             brake_on;
  logic [MAX_LAMPS-1:0] full_mask;
  logic [LAMPS-1:0] seq_mask;
  logic [LAMPS-1:0] brake_mask;

  assign decoded     = decode_mode(bus.left, bus.right, bus.hazard);
  assign mode_change = (decoded != mode_q);

  tail_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mode_change),
    .tick    (tick)
  );

  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (mode_change) begin
      mode_d = decoded;
      step_d = (decoded == MODE_IDLE) ? '0 : SW'(1);
    end else if (tick) begin
      unique case (mode_q)
        MODE_LEFT, MODE_RIGHT: step_d = (step_q == LAST_STEP) ? '0 : step_q + SW'(1);
        MODE_HAZARD:           step_d = (step_q == '0) ? SW'(1) : '0;
        default:               step_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_IDLE;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

`ifdef SEQ_TAIL_BRAKE_EN
  // Brake is registered so lamps stay a pure decode of state, one clk behind the request.
  logic brake_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) brake_q <= 1'b0;
    else          brake_q <= bus.brake;
  end
  assign brake_on = brake_q;
`else
  assign brake_on = 1'b0;
`endif

  assign full_mask  = thermo(4'(step_q));
  assign seq_mask   = full_mask[LAMPS-1:0];
  assign brake_mask = brake_on ? '1 : '0;

  always_comb begin
    bus.lamps_l = '0;
    bus.lamps_r = '0;
    unique case (mode_q)
      MODE_LEFT: begin
        bus.lamps_l = seq_mask;
        bus.lamps_r = brake_mask;
      end
      MODE_RIGHT: begin
        bus.lamps_l = brake_mask;
        bus.lamps_r = seq_mask;
      end
      MODE_HAZARD: begin
        bus.lamps_l = (step_q != '0) ? '1 : '0;
        bus.lamps_r = (step_q != '0) ? '1 : '0;
      end
      default: begin
        bus.lamps_l = brake_mask;
        bus.lamps_r = brake_mask;
      end
    endcase
  end

  assign bus.mode      = mode_q;
  assign bus.step_tick = tick;

endmodule

// File: tb/tb_seq_tail_light_ctrl.sv
// Directed bench for seq_tail_light_ctrl: a 3-lamp/2-cycle unit driven from a vector table,
// plus a 5-lamp/1-cycle unit and hand sequences for async reset and (optionally) brake.
module tb_seq_tail_light_ctrl;
  import tail_light_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_tail_light_ctrl_if #(.LAMPS(3)) bus_a ();
  seq_tail_light_ctrl_if #(.LAMPS(5)) bus_b ();

  seq_tail_light_ctrl #(.LAMPS(3), .TICK_DIV(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  seq_tail_light_ctrl #(.LAMPS(5), .TICK_DIV(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  typedef struct {
    logic       l, r, h;
    logic [2:0] el, er;
    logic [1:0] em;
    logic       et;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic l, input logic r, input logic h,
                              input logic [2:0] el, input logic [2:0] er,
                              input logic [1:0] em, input logic et);
    vec_t v;
    v.l = l; v.r = r; v.h = h; v.el = el; v.er = er; v.em = em; v.et = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] el, input logic [2:0] er,
                         input logic [1:0] em);
    check({tag, ".lamps_l"}, 32'(bus_a.lamps_l), 32'(el));
    check({tag, ".lamps_r"}, 32'(bus_a.lamps_r), 32'(er));
    check({tag, ".mode"},    32'(bus_a.mode),    32'(em));
  endtask

  initial begin
    // Left turn from reset, switch to right at 011, both turns, hazard alone, idle, priorities.
    vecs[0]  = mk(1,0,0, 3'b001,3'b000,2'd1,1'b0);
    vecs[1]  = mk(1,0,0, 3'b001,3'b000,2'd1,1'b1);
    vecs[2]  = mk(1,0,0, 3'b011,3'b000,2'd1,1'b0);
    vecs[3]  = mk(1,0,0, 3'b011,3'b000,2'd1,1'b1);
    vecs[4]  = mk(1,0,0, 3'b111,3'b000,2'd1,1'b0);
    vecs[5]  = mk(1,0,0, 3'b111,3'b000,2'd1,1'b1);
    vecs[6]  = mk(1,0,0, 3'b000,3'b000,2'd1,1'b0);
    vecs[7]  = mk(1,0,0, 3'b000,3'b000,2'd1,1'b1);
    vecs[8]  = mk(1,0,0, 3'b001,3'b000,2'd1,1'b0);
    vecs[9]  = mk(1,0,0, 3'b001,3'b000,2'd1,1'b1);
    vecs[10] = mk(1,0,0, 3'b011,3'b000,2'd1,1'b0);
    vecs[11] = mk(0,1,0, 3'b000,3'b001,2'd2,1'b0);
    vecs[12] = mk(0,1,0, 3'b000,3'b001,2'd2,1'b1);
    vecs[13] = mk(0,1,0, 3'b000,3'b011,2'd2,1'b0);
    vecs[14] = mk(0,1,0, 3'b000,3'b011,2'd2,1'b1);
    vecs[15] = mk(1,1,0, 3'b111,3'b111,2'd3,1'b0);
    vecs[16] = mk(1,1,0, 3'b111,3'b111,2'd3,1'b1);
    vecs[17] = mk(1,1,0, 3'b000,3'b000,2'd3,1'b0);
    vecs[18] = mk(1,1,0, 3'b000,3'b000,2'd3,1'b1);
    vecs[19] = mk(1,1,0, 3'b111,3'b111,2'd3,1'b0);
    vecs[20] = mk(0,0,1, 3'b111,3'b111,2'd3,1'b1);
    vecs[21] = mk(0,0,1, 3'b000,3'b000,2'd3,1'b0);
    vecs[22] = mk(0,0,1, 3'b000,3'b000,2'd3,1'b1);
    vecs[23] = mk(0,0,0, 3'b000,3'b000,2'd0,1'b0);
    vecs[24] = mk(0,0,0, 3'b000,3'b000,2'd0,1'b1);
    vecs[25] = mk(0,0,0, 3'b000,3'b000,2'd0,1'b0);
    vecs[26] = mk(1,0,1, 3'b111,3'b111,2'd3,1'b0);
    vecs[27] = mk(0,1,1, 3'b111,3'b111,2'd3,1'b1);
    vecs[28] = mk(0,1,0, 3'b000,3'b001,2'd2,1'b0);
    vecs[29] = mk(1,0,0, 3'b001,3'b000,2'd1,1'b0);

    bus_a.left = 1'b0; bus_a.right = 1'b0; bus_a.hazard = 1'b0;
    bus_b.left = 1'b0; bus_b.right = 1'b0; bus_b.hazard = 1'b0;
`ifdef SEQ_TAIL_BRAKE_EN
    bus_a.brake = 1'b0; bus_b.brake = 1'b0;
`endif

    // Reset state, with left already requested.
    #2;
    bus_a.left = 1'b1;
    check_a("reset", 3'b000, 3'b000, 2'd0);
    check("reset.step_tick", 32'(bus_a.step_tick), 32'd0);
    check("reset_b.mode", 32'(bus_b.mode), 32'd0);
    #5 reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      bus_a.left   = vecs[i].l;
      bus_a.right  = vecs[i].r;
      bus_a.hazard = vecs[i].h;
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].em);
      check($sformatf("vec%0d.step_tick", i), 32'(bus_a.step_tick), 32'(vecs[i].et));
    end

    // Asynchronous reset asserted mid-hazard, between clock edges.
    bus_a.hazard = 1'b1;
    @(posedge clk); #1;
    check_a("haz_pre_reset", 3'b111, 3'b111, 2'd3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_a("async_reset", 3'b000, 3'b000, 2'd0);
    check("async_reset.step_tick", 32'(bus_a.step_tick), 32'd0);
    bus_a.left = 1'b0; bus_a.hazard = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_a($sformatf("post_reset_idle%0d", i), 3'b000, 3'b000, 2'd0);
    end
    bus_a.left = 1'b1;
    @(posedge clk); #1;
    check_a("post_reset_left", 3'b001, 3'b000, 2'd1);
    bus_a.left = 1'b0;

    // Five lamps, one cycle per step: advance every clock, tick always high.
    bus_b.right = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      logic [4:0] exp_r;
      int s;
      @(posedge clk); #1;
      s = n % 6;
      exp_r = 5'((1 << s) - 1);
      check($sformatf("b_step%0d.lamps_r", n), 32'(bus_b.lamps_r), 32'(exp_r));
      check($sformatf("b_step%0d.lamps_l", n), 32'(bus_b.lamps_l), 32'd0);
      check($sformatf("b_step%0d.step_tick", n), 32'(bus_b.step_tick), 32'd1);
      check($sformatf("b_step%0d.mode", n), 32'(bus_b.mode), 32'd2);
    end
    bus_b.right = 1'b0;

`ifdef SEQ_TAIL_BRAKE_EN
    // Brake: idle all-on, lights the inactive turn side, ignored under hazard.
    @(posedge clk); #1;
    check_a("brk_idle_off", 3'b000, 3'b000, 2'd0);
    bus_a.brake = 1'b1;
    @(posedge clk); #1;
    check_a("brk_idle", 3'b111, 3'b111, 2'd0);
    bus_a.left = 1'b1;
    @(posedge clk); #1;
    check_a("brk_left0", 3'b001, 3'b111, 2'd1);
    @(posedge clk); #1;
    check_a("brk_left1", 3'b001, 3'b111, 2'd1);
    @(posedge clk); #1;
    check_a("brk_left2", 3'b011, 3'b111, 2'd1);
    bus_a.hazard = 1'b1;
    @(posedge clk); #1;
    check_a("brk_haz0", 3'b111, 3'b111, 2'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_a("brk_haz2", 3'b000, 3'b000, 2'd3);
    bus_a.brake = 1'b0; bus_a.hazard = 1'b0; bus_a.left = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
